// File: rtl/weight_update_mid_seq_if.sv
// Handshake and data bundle for the sequential hidden-to-output weight updater.
// The master drives step requests and weight loads; the slave owns the weight bank.
interface weight_update_mid_seq_if #(
  parameter int unsigned N_MID = 3,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned IdxW = (N_MID > 1) ? $clog2(N_MID) : 1;

  logic                   start;
  logic [WIDTH-1:0]       teach;
  logic [WIDTH-1:0]       net_out;
  logic [N_MID*WIDTH-1:0] mid;
  logic                   wr_en;
  logic [IdxW-1:0]        wr_idx;
  logic [WIDTH-1:0]       wr_data;
  logic [N_MID*WIDTH-1:0] weight;
  logic [WIDTH-1:0]       error;
  logic                   busy;
  logic                   done;

  modport master (
    output start, teach, net_out, mid, wr_en, wr_idx, wr_data,
    input  weight, error, busy, done
  );

  modport slave (
    input  start, teach, net_out, mid, wr_en, wr_idx, wr_data,
    output weight, error, busy, done
  );
endinterface

// File: rtl/weight_update_mid_seq.sv
// Sequential hidden-to-output weight updater: latches one error per step, then walks
// the weight bank through a single shared saturating multiply-accumulate, one lane per cycle.
module weight_update_mid_seq #(
  parameter int unsigned N_MID    = 3,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned LR_SHIFT = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  weight_update_mid_seq_if.slave bus
);
  localparam int unsigned IdxW = (N_MID > 1) ? $clog2(N_MID) : 1;
  localparam int unsigned W2   = 2 * WIDTH;

  typedef logic signed [W2-1:0] wide_t;
  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam wide_t MaxW = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam wide_t MinW = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat(input wide_t v);
    if (v > MaxW) begin
      return MaxW[WIDTH-1:0];
    end else if (v < MinW) begin
      return MinW[WIDTH-1:0];
    end
    return v[WIDTH-1:0];
  endfunction

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic signed [WIDTH-1:0] err_q;
  logic signed [WIDTH-1:0] weight_q [N_MID];
  logic signed [WIDTH-1:0] mid_q    [N_MID];
  logic                    busy_q;
  logic                    done_q;

  logic signed [WIDTH-1:0] teach_s, out_s, mid_sel, w_sel, err_next, delta, w_next;
  wide_t                   prod, shifted;

  assign teach_s  = bus.teach;
  assign out_s    = bus.net_out;
  assign mid_sel  = mid_q[idx_q];
  assign w_sel    = weight_q[idx_q];
  assign err_next = sat(wide_t'(teach_s) - wide_t'(out_s));

  // Full-width product is exact; the arithmetic shift floors toward -inf.
  assign prod     = wide_t'(err_q) * wide_t'(mid_sel);
  assign shifted  = prod >>> (FRAC + LR_SHIFT);
  assign delta    = sat(shifted);
  assign w_next   = sat(wide_t'(w_sel) + wide_t'(delta));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < N_MID; k++) begin
        weight_q[k] <= '0;
        mid_q[k]    <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          // A load wins over a step request presented in the same cycle.
          if (bus.wr_en) begin
            if (32'(bus.wr_idx) < N_MID) begin
              weight_q[bus.wr_idx] <= bus.wr_data;
            end
          end else if (bus.start) begin
            for (int k = 0; k < N_MID; k++) begin
              mid_q[k] <= bus.mid[k*WIDTH +: WIDTH];
            end
            err_q   <= err_next;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          weight_q[idx_q] <= w_next;
          if (idx_q == IdxW'(N_MID - 1)) begin
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < N_MID; k++) begin : g_lane
    assign bus.weight[k*WIDTH +: WIDTH] = weight_q[k];
  end

  assign bus.error = err_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_weight_update_mid_seq.sv
// Directed bench for weight_update_mid_seq at N_MID = 3, plus N_MID = 1 and 8 instances
// checked against a small saturating reference model.
module tb_weight_update_mid_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  weight_update_mid_seq_if #(.N_MID(3), .WIDTH(W)) b3 ();
  weight_update_mid_seq_if #(.N_MID(1), .WIDTH(W)) b1 ();
  weight_update_mid_seq_if #(.N_MID(8), .WIDTH(W)) b8 ();

  weight_update_mid_seq #(.N_MID(3), .WIDTH(W), .FRAC(8), .LR_SHIFT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );
  weight_update_mid_seq #(.N_MID(1), .WIDTH(W), .FRAC(8), .LR_SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  weight_update_mid_seq #(.N_MID(8), .WIDTH(W), .FRAC(8), .LR_SHIFT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int model_delta(input int e, input int m);
    return sat16((longint'(e) * longint'(m)) >>> 9);
  endfunction

  function automatic int rnd_word(input int s);
    if (s % 4 == 0) return int'($urandom_range(65535)) - 32768;
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic idle_all();
    b3.start = 1'b0; b3.teach = '0; b3.net_out = '0; b3.mid = '0;
    b3.wr_en = 1'b0; b3.wr_idx = '0; b3.wr_data = '0;
    b1.start = 1'b0; b1.teach = '0; b1.net_out = '0; b1.mid = '0;
    b1.wr_en = 1'b0; b1.wr_idx = '0; b1.wr_data = '0;
    b8.start = 1'b0; b8.teach = '0; b8.net_out = '0; b8.mid = '0;
    b8.wr_en = 1'b0; b8.wr_idx = '0; b8.wr_data = '0;
  endtask

  task automatic load3(input int k, input int v);
    @(negedge clk);
    b3.wr_en = 1'b1; b3.wr_idx = 2'(k); b3.wr_data = 16'(v);
    @(negedge clk);
    b3.wr_en = 1'b0;
  endtask

  // Returns #1 after the accepting edge E0.
  task automatic start3(input int t, input int o, input int m0, input int m1, input int m2);
    @(negedge clk);
    b3.teach = 16'(t); b3.net_out = 16'(o); b3.mid = {16'(m2), 16'(m1), 16'(m0)};
    b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
  endtask

  task automatic wait_done3(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (b3.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s: done observed 0 within 20 cycles, required 1", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    #1;
    checks++;
    if (b3.weight !== 48'd0 || b3.error !== 16'd0 || b3.busy !== 1'b0 || b3.done !== 1'b0) begin
      errors++; $display("FAIL reset_init: w=%h err=%h busy=%b done=%b, required all 0",
                         b3.weight, b3.error, b3.busy, b3.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load3(0, 256);
    start3(256, 64, 128, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (b3.weight[15:0] !== 16'd304) begin
      errors++; $display("FAIL reset_pre: lane0=%0d, required 304", b3.weight[15:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b3.weight !== 48'd0 || b3.error !== 16'd0 || b3.busy !== 1'b0 || b3.done !== 1'b0) begin
      errors++; $display("FAIL reset_async: w=%h err=%h busy=%b done=%b, required all 0",
                         b3.weight, b3.error, b3.busy, b3.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b3.busy !== 1'b0 || b3.done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b, required 0 0", b3.busy, b3.done);
    end
    load3(2, 5);
    checks++;
    if (b3.weight !== {16'd5, 32'd0}) begin
      errors++; $display("FAIL reset_load: w=%h, required 000500000000", b3.weight);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) load3(k, 256);
    start3(256, 64, 128, 256, 0);
    checks++;
    if (b3.error !== 16'd192 || b3.busy !== 1'b1 || b3.weight !== {3{16'd256}}) begin
      errors++; $display("FAIL basic_e0: err=%0d busy=%b w=%h, required 192 1 010001000100",
                         b3.error, b3.busy, b3.weight);
    end
    @(posedge clk); #1;
    checks++;
    if (b3.weight !== {16'd256, 16'd256, 16'd304}) begin
      errors++; $display("FAIL basic_e1: w=%h, required 010001000130", b3.weight);
    end
    @(posedge clk); #1;
    checks++;
    if (b3.weight !== {16'd256, 16'd352, 16'd304} || b3.done !== 1'b0) begin
      errors++; $display("FAIL basic_e2: w=%h done=%b, required 010001600130 0", b3.weight, b3.done);
    end
    @(posedge clk); #1;
    checks++;
    if (b3.done !== 1'b1 || b3.busy !== 1'b1 || b3.weight !== {16'd256, 16'd352, 16'd304}) begin
      errors++; $display("FAIL basic_e3: done=%b busy=%b w=%h, required 1 1 010001600130",
                         b3.done, b3.busy, b3.weight);
    end
    @(posedge clk); #1;
    checks++;
    if (b3.done !== 1'b0 || b3.busy !== 1'b0) begin
      errors++; $display("FAIL basic_e4: done=%b busy=%b, required 0 0", b3.done, b3.busy);
    end
  endtask

  task automatic test_negative();
    load3(0, 0);
    start3(0, 1, 1, 0, 0);
    wait_done3("neg_done");
    checks++;
    if (b3.error !== 16'hffff || b3.weight[15:0] !== 16'hffff) begin
      errors++; $display("FAIL neg_floor: err=%h lane0=%h, required ffff ffff",
                         b3.error, b3.weight[15:0]);
    end
  endtask

  task automatic test_saturation();
    load3(0, 32767);
    start3(32767, 0, 32767, 0, 0);
    wait_done3("sat_pos_done");
    checks++;
    if (b3.error !== 16'h7fff || b3.weight[15:0] !== 16'h7fff) begin
      errors++; $display("FAIL sat_pos: err=%h lane0=%h, required 7fff 7fff",
                         b3.error, b3.weight[15:0]);
    end
    load3(0, -32768);
    start3(-32768, 1, 32767, 0, 0);
    wait_done3("sat_neg_done");
    checks++;
    if (b3.error !== 16'h8000 || b3.weight[15:0] !== 16'h8000) begin
      errors++; $display("FAIL sat_neg: err=%h lane0=%h, required 8000 8000",
                         b3.error, b3.weight[15:0]);
    end
  endtask

  task automatic test_handshake();
    int dcnt = 0;
    for (int k = 0; k < 3; k++) load3(k, 0);
    @(negedge clk);
    b3.wr_en = 1'b1; b3.wr_idx = 2'd1; b3.wr_data = 16'd100;
    b3.start = 1'b1; b3.teach = 16'd256; b3.net_out = 16'd0; b3.mid = {3{16'd256}};
    @(posedge clk); #1;
    b3.wr_en = 1'b0; b3.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b3.weight !== {16'd0, 16'd100, 16'd0} || b3.busy !== 1'b0) begin
      errors++; $display("FAIL wr_priority: w=%h busy=%b, required 000000640000 0", b3.weight, b3.busy);
    end
    load3(1, 0);
    start3(256, 0, 256, 0, 0);
    @(posedge clk); #1;
    b3.start = 1'b1; b3.wr_en = 1'b1; b3.wr_idx = 2'd2; b3.wr_data = 16'd999;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        b3.start = 1'b0; b3.wr_en = 1'b0;
      end
      if (b3.done) dcnt++;
    end
    checks++;
    if (dcnt != 1 || b3.busy !== 1'b0) begin
      errors++; $display("FAIL start_in_calc: done pulses=%0d busy=%b, required 1 0", dcnt, b3.busy);
    end
    checks++;
    if (b3.weight !== {16'd0, 16'd0, 16'd128}) begin
      errors++; $display("FAIL wr_in_calc: w=%h, required 000000000080", b3.weight);
    end
    load3(3, 1234);
    checks++;
    if (b3.weight !== {16'd0, 16'd0, 16'd128}) begin
      errors++; $display("FAIL wr_oob: w=%h, required 000000000080", b3.weight);
    end
  endtask

  task automatic test_param8();
    int w[8];
    int m[8];
    int t, o, e, cnt;
    bit seen;
    logic [127:0] mv;
    for (int k = 0; k < 8; k++) begin
      w[k] = int'($urandom_range(65535)) - 32768;
      @(negedge clk);
      b8.wr_en = 1'b1; b8.wr_idx = 3'(k); b8.wr_data = 16'(w[k]);
    end
    @(negedge clk);
    b8.wr_en = 1'b0;
    for (int s = 0; s < 100; s++) begin
      t = rnd_word(s); o = rnd_word(s);
      for (int k = 0; k < 8; k++) begin
        m[k] = rnd_word(s + k);
        mv[k*16 +: 16] = 16'(m[k]);
      end
      @(negedge clk);
      b8.teach = 16'(t); b8.net_out = 16'(o); b8.mid = mv; b8.start = 1'b1;
      @(posedge clk); #1;
      b8.start = 1'b0;
      e = sat16(longint'(t) - longint'(o));
      for (int k = 0; k < 8; k++) w[k] = sat16(longint'(w[k]) + longint'(model_delta(e, m[k])));
      checks++;
      if (b8.error !== 16'(e)) begin
        errors++; $display("FAIL p8_err step %0d: err=%h, required %h", s, b8.error, 16'(e));
      end
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 12) begin
        @(posedge clk); #1;
        cnt++;
        if (b8.done) seen = 1'b1;
      end
      checks++;
      if (!seen || cnt != 8) begin
        errors++; $display("FAIL p8_latency step %0d: cycles=%0d seen=%b, required 8 1", s, cnt, seen);
      end
      @(posedge clk); #1;
      checks++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin
        errors++; $display("FAIL p8_idle step %0d: busy=%b done=%b, required 0 0", s, b8.busy, b8.done);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (b8.weight[k*16 +: 16] !== 16'(w[k])) begin
        errors++; $display("FAIL p8_weight lane %0d: got %h, required %h", k, b8.weight[k*16 +: 16],
                           16'(w[k]));
      end
    end
  endtask

  task automatic test_param1();
    int w, m, t, o, e, cnt;
    bit seen;
    w = int'($urandom_range(65535)) - 32768;
    @(negedge clk);
    b1.wr_en = 1'b1; b1.wr_idx = 1'b0; b1.wr_data = 16'(w);
    @(negedge clk);
    b1.wr_en = 1'b0;
    for (int s = 0; s < 100; s++) begin
      t = rnd_word(s); o = rnd_word(s); m = rnd_word(s + 1);
      @(negedge clk);
      b1.teach = 16'(t); b1.net_out = 16'(o); b1.mid = 16'(m); b1.start = 1'b1;
      @(posedge clk); #1;
      b1.start = 1'b0;
      e = sat16(longint'(t) - longint'(o));
      w = sat16(longint'(w) + longint'(model_delta(e, m)));
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 6) begin
        @(posedge clk); #1;
        cnt++;
        if (b1.done) seen = 1'b1;
      end
      checks++;
      if (!seen || cnt != 1 || b1.weight !== 16'(w)) begin
        errors++; $display("FAIL p1 step %0d: cycles=%0d seen=%b w=%h, required 1 1 %h",
                           s, cnt, seen, b1.weight, 16'(w));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_handshake();
    test_param1();
    test_param8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
